// File: rtl/mmio_fifo_port_if.sv
// Bus and stream signals of the MMIO FIFO port.
// The slave modport is the port block; master is the processor/stream side.
interface mmio_fifo_port_if;
    logic       data_mem_rd_enb;
    logic       data_mem_wr_enb;
    logic [7:0] data_mem_addr;
    logic [7:0] data_mem_wr_data;
    logic [7:0] rd_data;
    logic       rd_hit;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport slave (
        input  data_mem_rd_enb, data_mem_wr_enb,
        input  data_mem_addr, data_mem_wr_data,
        output rd_data, rd_hit,
        output tx_valid, tx_data,
        input  tx_ready,
        input  rx_valid, rx_data,
        output rx_ready
    );

    modport master (
        output data_mem_rd_enb, data_mem_wr_enb,
        output data_mem_addr, data_mem_wr_data,
        input  rd_data, rd_hit,
        input  tx_valid, tx_data,
        output tx_ready,
        output rx_valid, rx_data,
        input  rx_ready
    );
endinterface

// File: rtl/mmio_fifo_port.sv
// Memory-mapped TX/RX byte FIFO port on the data-memory bus.
// Offsets: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL.
module mmio_fifo_port #(
    parameter logic [7:0] BASE  = 8'hF0,
    parameter int         DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    mmio_fifo_port_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_ovf_q, tx_ovf_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_hit_q, rd_hit_d;

    logic          hit, bus_wr, bus_rd;
    logic [1:0]    off;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_clr, rx_clr, ovf_clr;
    logic          tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
    logic [3:0]    tx_cnt4, rx_cnt4;
    logic [7:0]    rd_val;

    assign hit    = bus.data_mem_addr[7:2] == BASE[7:2];
    assign off    = bus.data_mem_addr[1:0];
    assign bus_wr = bus.data_mem_wr_enb & hit;
    // A simultaneous write suppresses the read entirely.
    assign bus_rd = bus.data_mem_rd_enb & ~bus.data_mem_wr_enb & hit;

    assign tx_full  = tx_cnt_q == CW'(DEPTH);
    assign tx_empty = tx_cnt_q == '0;
    assign rx_full  = rx_cnt_q == CW'(DEPTH);
    assign rx_empty = rx_cnt_q == '0;
    assign tx_cnt4  = 4'(tx_cnt_q);
    assign rx_cnt4  = 4'(rx_cnt_q);

    assign tx_clr  = bus_wr & (off == 2'd3) & bus.data_mem_wr_data[0];
    assign rx_clr  = bus_wr & (off == 2'd3) & bus.data_mem_wr_data[1];
    assign ovf_clr = bus_wr & (off == 2'd3) & bus.data_mem_wr_data[7];

    // Clears beat any same-cycle push or pop on the same FIFO.
    assign tx_push_req = bus_wr & (off == 2'd0);
    assign tx_push     = tx_push_req & ~tx_full & ~tx_clr;
    assign tx_pop      = ~tx_empty & bus.tx_ready & ~tx_clr;
    assign rx_push     = bus.rx_valid & ~rx_full & ~rx_clr;
    assign rx_pop      = bus_rd & (off == 2'd1) & ~rx_empty & ~rx_clr;

    assign bus.tx_valid = ~tx_empty;
    assign bus.tx_data  = tx_mem_q[tx_rp_q];
    assign bus.rx_ready = ~rx_full;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_hit   = rd_hit_q;

    // Register file read mux for the current bus offset.
    always_comb begin
        rd_val = 8'h00;
        case (off)
            2'd0: rd_val = 8'h00;
            2'd1: rd_val = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
            2'd2: rd_val = {tx_full, tx_empty, rx_full, rx_empty, rx_cnt4};
            default: rd_val = {tx_ovf_q, 3'b000, tx_cnt4};
        endcase
    end

    // Next-state for pointers, counts, overflow flag and read response.
    always_comb begin
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        if (tx_clr) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = '0;
        end else begin
            if (tx_push) tx_wp_d = tx_wp_q + AW'(1);
            if (tx_pop)  tx_rp_d = tx_rp_q + AW'(1);
            tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        end
        if (rx_clr) begin
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_cnt_d = '0;
        end else begin
            if (rx_push) rx_wp_d = rx_wp_q + AW'(1);
            if (rx_pop)  rx_rp_d = rx_rp_q + AW'(1);
            rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        end
        tx_ovf_d  = (tx_ovf_q & ~ovf_clr) | (tx_push_req & tx_full);
        rd_hit_d  = bus_rd;
        rd_data_d = bus_rd ? rd_val : rd_data_q;
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            tx_cnt_q  <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            rx_cnt_q  <= '0;
            tx_ovf_q  <= 1'b0;
            rd_data_q <= 8'h00;
            rd_hit_q  <= 1'b0;
        end else begin
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_ovf_q  <= tx_ovf_d;
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
        end
    end

    // FIFO storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clock) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= bus.data_mem_wr_data;
        if (rx_push) rx_mem_q[rx_wp_q] <= bus.rx_data;
    end
endmodule

// File: tb/tb_mmio_fifo_port.sv
// Randomized bench for mmio_fifo_port against a queue-based model.
// Directed test-plan sequences first, then a random phase.
module tb_mmio_fifo_port;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mmio_fifo_port_if bus();

    mmio_fifo_port #(.BASE(8'hF0), .DEPTH(8)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit         ovf;
    logic [7:0] exp_rd;
    bit         exp_hit;
    bit         armed = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] reg_val(input logic [1:0] off);
        logic [7:0] v;
        case (off)
            2'd0: v = 8'h00;
            2'd1: v = (rxq.size() != 0) ? rxq[0] : 8'h00;
            2'd2: v = {txq.size() == 8, txq.size() == 0,
                       rxq.size() == 8, rxq.size() == 0,
                       4'(rxq.size())};
            default: v = {ovf, 3'b000, 4'(txq.size())};
        endcase
        return v;
    endfunction

    // Apply one clock edge of the specification's rules to the model.
    task automatic model_edge();
        bit         hit, wr, rd, txclr, rxclr, oclr, full, rxfill, rxpop;
        logic [1:0] off;
        logic [7:0] val;
        if (rst) begin
            txq.delete();
            rxq.delete();
            ovf     = 1'b0;
            exp_rd  = 8'h00;
            exp_hit = 1'b0;
            return;
        end
        hit    = bus.data_mem_addr[7:2] == 6'h3C;
        off    = bus.data_mem_addr[1:0];
        wr     = bus.data_mem_wr_enb && hit;
        rd     = bus.data_mem_rd_enb && !bus.data_mem_wr_enb && hit;
        txclr  = wr && off == 2'd3 && bus.data_mem_wr_data[0];
        rxclr  = wr && off == 2'd3 && bus.data_mem_wr_data[1];
        oclr   = wr && off == 2'd3 && bus.data_mem_wr_data[7];
        val    = reg_val(off);
        rxfill = rxq.size() < 8 && bus.rx_valid;
        rxpop  = rd && off == 2'd1 && rxq.size() != 0;
        if (txclr) begin
            txq.delete();
        end else begin
            full = txq.size() == 8;
            if (txq.size() != 0 && bus.tx_ready) void'(txq.pop_front());
            if (wr && off == 2'd0) begin
                if (full) ovf = 1'b1;
                else txq.push_back(bus.data_mem_wr_data);
            end
        end
        if (oclr) ovf = 1'b0;
        if (rxclr) begin
            rxq.delete();
        end else begin
            if (rxpop) void'(rxq.pop_front());
            if (rxfill) rxq.push_back(bus.rx_data);
        end
        exp_hit = rd;
        if (rd) exp_rd = val;
    endtask

    task automatic cyc();
        if (armed) begin
            check("tx_valid", bus.tx_valid, txq.size() != 0);
            if (txq.size() != 0) check("tx_data", bus.tx_data, txq[0]);
            check("rx_ready", bus.rx_ready, rxq.size() < 8);
        end
        @(posedge clk);
        model_edge();
        #1;
        armed = 1'b1;
        check("rd_data", bus.rd_data, exp_rd);
        check("rd_hit", bus.rd_hit, exp_hit);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.data_mem_rd_enb = 1'b0;
        bus.data_mem_wr_enb = 1'b0;
    endtask

    task automatic bwr(input logic [1:0] off, input logic [7:0] d);
        bus.data_mem_wr_enb  = 1'b1;
        bus.data_mem_rd_enb  = 1'b0;
        bus.data_mem_addr    = {6'h3C, off};
        bus.data_mem_wr_data = d;
        cyc();
        idle();
    endtask

    task automatic brd(input logic [1:0] off);
        bus.data_mem_rd_enb = 1'b1;
        bus.data_mem_wr_enb = 1'b0;
        bus.data_mem_addr   = {6'h3C, off};
        cyc();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.data_mem_addr    = 8'h00;
        bus.data_mem_wr_data = 8'h00;
        bus.tx_ready         = 1'b0;
        bus.rx_valid         = 1'b0;
        bus.rx_data          = 8'h00;
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;

        brd(2'd2);
        check("status_rst", bus.rd_data, 8'h50);
        check("hit_rst", bus.rd_hit, 1'b1);

        for (int i = 1; i <= 8; i++) bwr(2'd0, 8'hA0 + 8'(i));
        bwr(2'd0, 8'hA9);
        brd(2'd3);
        check("ctrl_ovf", bus.rd_data, 8'h88);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 9; i++) cyc();
        bwr(2'd3, 8'h80);
        brd(2'd3);
        check("ovf_clr", bus.rd_data, 8'h00);

        for (int i = 0; i < 8; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'h11 + 8'(i);
            cyc();
        end
        bus.rx_valid = 1'b0;
        check("rx_full", bus.rx_ready, 1'b0);
        for (int i = 0; i < 8; i++) brd(2'd1);
        brd(2'd1);
        check("rx_empty_rd", bus.rd_data, 8'h00);
        brd(2'd2);
        check("status_end", bus.rd_data, 8'h50);

        for (int i = 0; i < 3; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'h21 + 8'(i);
            cyc();
        end
        bus.rx_data = 8'h24;
        brd(2'd1);
        bus.rx_valid = 1'b0;
        check("pop_push_rd", bus.rd_data, 8'h21);
        brd(2'd2);
        check("pop_push_cnt", bus.rd_data, 8'h43);
        for (int i = 0; i < 3; i++) brd(2'd1);

        bus.tx_ready         = 1'b0;
        bus.data_mem_rd_enb  = 1'b1;
        bus.data_mem_wr_enb  = 1'b1;
        bus.data_mem_addr    = 8'hF0;
        bus.data_mem_wr_data = 8'h5A;
        cyc();
        idle();
        check("rdwr_hit", bus.rd_hit, 1'b0);
        check("rdwr_push", bus.tx_valid, 1'b1);

        bus.data_mem_rd_enb = 1'b1;
        bus.data_mem_addr   = 8'h40;
        cyc();
        idle();
        check("miss_hit", bus.rd_hit, 1'b0);

        for (int i = 0; i < 4; i++) bwr(2'd0, 8'h60 + 8'(i));
        brd(2'd3);
        check("tx5", bus.rd_data, 8'h05);
        rst                  = 1'b1;
        bus.data_mem_wr_enb  = 1'b1;
        bus.data_mem_addr    = 8'hF0;
        bus.data_mem_wr_data = 8'h77;
        cyc();
        rst = 1'b0;
        idle();
        brd(2'd3);
        check("rst_ctrl", bus.rd_data, 8'h00);
        check("rst_txv", bus.tx_valid, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            int op;
            rst = ($urandom_range(0, 299) == 0);
            op  = $urandom_range(0, 3);
            bus.data_mem_rd_enb = (op == 1 || op == 3);
            bus.data_mem_wr_enb = (op == 2 || op == 3);
            if ($urandom_range(0, 9) == 0)
                bus.data_mem_addr = 8'($urandom);
            else
                bus.data_mem_addr = {6'h3C, 2'($urandom)};
            bus.data_mem_wr_data = 8'($urandom);
            if (bus.data_mem_addr[1:0] == 2'd3 && $urandom_range(0, 3) != 0)
                bus.data_mem_wr_data = 8'h00;
            bus.tx_ready = 1'($urandom);
            bus.rx_valid = 1'($urandom);
            bus.rx_data  = 8'($urandom);
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
